// File: rtl/bnn_frame_loader.sv
// Purpose: binarise a raster-order grayscale frame into a bit-plane for a BNN, then capture the argmax of its class scores.
// Latency: result_valid_o rises SETTLE_CYCLES+1 cycles after the edge that accepts the last pixel of a frame.
// Backpressure: pix_ready_o is low outside LOAD; the result is held stable until result_ready_i is seen in RESULT.
module bnn_frame_loader #(
  parameter int IMG_W         = 64,
  parameter int IMG_H         = 64,
  parameter int PIX_W         = 8,
  parameter int N_CLASS       = 3,
  parameter int SCORE_W       = 7,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [PIX_W-1:0]                       pix_i,
  input  logic                                   pix_valid_i,
  output logic                                   pix_ready_o,
  input  logic [PIX_W-1:0]                       bin_thr_i,
  output logic [0:0][IMG_H-1:0][IMG_W-1:0]       layer_o,
  input  logic [N_CLASS-1:0][SCORE_W-1:0]        scores_i,
  output logic [1:0]                             class_o,
  output logic [SCORE_W-1:0]                     score_o,
  output logic                                   result_valid_o,
  input  logic                                   result_ready_i,
  output logic                                   busy_o
);

  localparam int N_PIX = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(N_PIX);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   pix_cnt;
  logic [3:0]         settle_cnt;
  logic [ROW_W-1:0]   pix_row;
  logic [COL_W-1:0]   pix_col;
  logic               pix_bit;
  logic               pix_acc;
  logic               last_pix;
  logic [1:0]         best_idx;
  logic [SCORE_W-1:0] best_score;

  // Pixel k lands at row k/IMG_W, column k%IMG_W of the bit-plane.
  assign pix_row  = ROW_W'(int'(pix_cnt) / IMG_W);
  assign pix_col  = COL_W'(int'(pix_cnt) % IMG_W);
  assign pix_bit  = (pix_i >= bin_thr_i);
  assign pix_acc  = pix_valid_i & pix_ready_o;
  assign last_pix = (pix_cnt == CNT_W'(N_PIX - 1));

  // Unsigned argmax; strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx   = 2'd0;
    best_score = scores_i[0];
    for (int i = 1; i < N_CLASS; i++) begin
      if (scores_i[i] > best_score) begin
        best_idx   = 2'(i);
        best_score = scores_i[i];
      end
    end
  end

  // Frame FSM: all outputs registered so they change only on clock edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= LOAD;
      pix_cnt        <= '0;
      settle_cnt     <= '0;
      layer_o        <= '0;
      class_o        <= 2'd0;
      score_o        <= '0;
      result_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      pix_ready_o    <= 1'b1;
    end else begin
      case (state)
        LOAD: begin
          if (pix_acc) begin
            layer_o[0][pix_row][pix_col] <= pix_bit;
            if (last_pix) begin
              pix_cnt     <= '0;
              settle_cnt  <= '0;
              state       <= SETTLE;
              pix_ready_o <= 1'b0;
              busy_o      <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + CNT_W'(1);
            end
          end
        end
        SETTLE: begin
          // One edge to enter SETTLE, SETTLE_CYCLES counted cycles, then sample the network.
          if (settle_cnt == 4'(SETTLE_CYCLES)) begin
            settle_cnt     <= '0;
            class_o        <= best_idx;
            score_o        <= best_score;
            result_valid_o <= 1'b1;
            state          <= RESULT;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        RESULT: begin
          if (result_ready_i) begin
            result_valid_o <= 1'b0;
            pix_ready_o    <= 1'b1;
            busy_o         <= 1'b0;
            state          <= LOAD;
          end
        end
        default: begin
          state          <= LOAD;
          pix_ready_o    <= 1'b1;
          busy_o         <= 1'b0;
          result_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_frame_loader.sv
// Purpose: directed bench for bnn_frame_loader with a result scoreboard and a bit-plane reference.
// Latency: checks result_valid_o rise at SETTLE_CYCLES+1 edges after the last accept.
// Backpressure: exercises held results and ignored pixels while not in LOAD.
module tb_bnn_frame_loader;

  localparam int N_PIX  = 4096;
  localparam int SETTLE = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [7:0]           pix_i;
  logic                 pix_valid_i;
  logic                 pix_ready_o;
  logic [7:0]           bin_thr_i;
  logic [0:0][63:0][63:0] layer_o;
  logic [2:0][6:0]      scores_i;
  logic [1:0]           class_o;
  logic [6:0]           score_o;
  logic                 result_valid_o;
  logic                 result_ready_i;
  logic                 busy_o;

  logic [N_PIX-1:0]     exp_layer;
  logic [8:0]           sb_q[$];
  int                   errors = 0;
  int                   checks = 0;

  always #5 clk_i = ~clk_i;

  bnn_frame_loader #(
    .IMG_W(64), .IMG_H(64), .PIX_W(8), .N_CLASS(3), .SCORE_W(7), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pix_i(pix_i), .pix_valid_i(pix_valid_i),
    .pix_ready_o(pix_ready_o), .bin_thr_i(bin_thr_i), .layer_o(layer_o),
    .scores_i(scores_i), .class_o(class_o), .score_o(score_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_layer(input string tag);
    int first;
    first = -1;
    for (int i = N_PIX - 1; i >= 0; i--) if (layer_o[0][i/64][i%64] !== exp_layer[i]) first = i;
    checks++;
    assert (layer_o[0] === exp_layer) else begin
      errors++;
      $error("FAIL %s first bad bit %0d observed=%b expected=%b", tag, first,
             layer_o[0][first/64][first%64], exp_layer[first]);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pix_ready"}, 32'(pix_ready_o), 1);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_valid"}, 32'(result_valid_o), 0);
    chk({tag, "_class"}, 32'(class_o), 0);
    chk({tag, "_score"}, 32'(score_o), 0);
    chk({tag, "_layer_ones"}, 32'($countones(layer_o[0])), 0);
  endtask

  function automatic logic [7:0] pixval(input int pat, input int k);
    case (pat)
      0:       return 8'(k % 256);
      1:       return 8'd255;
      2:       return 8'd0;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Offer pixels k0..k1-1 starting at the next falling edge; the last accept happens on the following rising edge.
  task automatic load_frame(input int pat, input logic [7:0] thr, input bit gapped,
                            input int k0, input int k1, output int cycles, output int first_acc);
    int k;
    logic v;
    logic tog;
    logic [7:0] p;
    k = k0; cycles = 0; first_acc = -1; tog = 1'b1;
    while (k < k1 && cycles < 20000) begin
      @(negedge clk_i);
      v = gapped ? tog : 1'b1;
      tog = ~tog;
      p = pixval(pat, k);
      pix_i = p; pix_valid_i = v; bin_thr_i = thr;
      if (v && pix_ready_o) begin
        exp_layer[k] = (p >= thr);
        if (first_acc < 0) first_acc = cycles;
        k++;
      end
      cycles++;
    end
    if (k < k1) chk("load_timeout", 32'(k), 32'(k1));
  endtask

  // Wait for the result while offering stray pixels, then compare against the scoreboard head.
  task automatic wait_result(input string tag, output int rise);
    int n;
    logic [8:0] e;
    n = 0; rise = -1;
    while (!result_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
      if (!result_valid_o) begin
        pix_valid_i = 1'b1; pix_i = 8'hFF; bin_thr_i = 8'd0;
        if (n == 1) begin
          chk({tag, "_settle_busy"}, 32'(busy_o), 1);
          chk({tag, "_settle_ready"}, 32'(pix_ready_o), 0);
        end
      end
    end
    if (!result_valid_o) begin
      chk({tag, "_result_timeout"}, 32'(result_valid_o), 1);
      return;
    end
    rise = n - 1;
    chk({tag, "_latency"}, 32'(rise), SETTLE + 1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_class"}, 32'(class_o), 32'(e[8:7]));
    chk({tag, "_score"}, 32'(score_o), 32'(e[6:0]));
    chk({tag, "_busy"}, 32'(busy_o), 1);
    chk({tag, "_pix_ready"}, 32'(pix_ready_o), 0);
    chk_layer({tag, "_layer"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, fa, rise, hi;
    rst_i = 1'b1; pix_i = '0; pix_valid_i = 1'b0; bin_thr_i = '0;
    scores_i = '0; result_ready_i = 1'b0;
    exp_layer = '0;
    repeat (3) @(negedge clk_i);
    chk_reset_outputs("reset");
    rst_i = 1'b0;

    // Ramp frame, tie between indices 0 and 1 at 90.
    scores_i = {7'd10, 7'd90, 7'd90};
    sb_q.push_back({2'd0, 7'd90});
    load_frame(0, 8'd128, 1'b0, 0, N_PIX, cyc, fa);
    chk("ramp_cycles", 32'(cyc), N_PIX);
    wait_result("ramp", rise);

    // Hold the result for 20 cycles while offering pixels.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      pix_valid_i = 1'b1; pix_i = 8'hFF; bin_thr_i = 8'd0;
      chk("bp_valid", 32'(result_valid_o), 1);
      chk("bp_class", 32'(class_o), 0);
      chk("bp_score", 32'(score_o), 90);
      chk("bp_pix_ready", 32'(pix_ready_o), 0);
    end
    chk_layer("bp_layer");
    result_ready_i = 1'b1;
    @(negedge clk_i);
    pix_valid_i = 1'b0; result_ready_i = 1'b0;
    chk("bp_release_valid", 32'(result_valid_o), 0);
    chk("bp_release_ready", 32'(pix_ready_o), 1);
    chk("bp_release_busy", 32'(busy_o), 0);
    chk_layer("bp_release_layer");

    // Gapped frame of 255 with threshold 0.
    scores_i = {7'd5, 7'd6, 7'd4};
    sb_q.push_back({2'd1, 7'd6});
    load_frame(1, 8'd0, 1'b1, 0, N_PIX, cyc, fa);
    chk("gap_cycles", 32'(cyc), 8191);
    wait_result("gap", rise);
    chk("gap_all_ones", 32'($countones(layer_o[0])), N_PIX);
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0; pix_valid_i = 1'b0;

    // Reset 2000 pixels into a frame.
    scores_i = {7'd127, 7'd3, 7'd100};
    load_frame(0, 8'd128, 1'b0, 0, 2000, cyc, fa);
    @(negedge clk_i);
    rst_i = 1'b1; pix_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_layer = '0;
    chk_reset_outputs("midrst");
    sb_q.push_back({2'd2, 7'd127});
    load_frame(2, 8'd1, 1'b0, 0, N_PIX - 1, cyc, fa);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      pix_valid_i = 1'b0;
      if (result_valid_o) hi++;
    end
    chk("midrst_no_early_result", 32'(hi), 0);
    chk("midrst_still_loading", 32'(pix_ready_o), 1);
    load_frame(2, 8'd1, 1'b0, N_PIX - 1, N_PIX, cyc, fa);
    wait_result("midrst", rise);
    chk("midrst_all_zero", 32'($countones(layer_o[0])), 0);

    // Back-to-back frames with result_ready_i held high.
    result_ready_i = 1'b1;
    scores_i = {7'd1, 7'd50, 7'd2};
    sb_q.push_back({2'd1, 7'd50});
    load_frame(3, 8'($urandom_range(1, 255)), 1'b0, 0, N_PIX, cyc, fa);
    chk("b2b_a_first_accept", 32'(fa), 0);
    wait_result("b2b_a", rise);
    scores_i = {7'd60, 7'd60, 7'd59};
    sb_q.push_back({2'd1, 7'd60});
    load_frame(3, 8'($urandom_range(1, 255)), 1'b0, 0, N_PIX, cyc, fa);
    chk("b2b_b_first_accept", 32'(fa), 0);
    wait_result("b2b_b", rise);
    @(negedge clk_i);
    pix_valid_i = 1'b0;
    chk("b2b_final_valid", 32'(result_valid_o), 0);
    chk("b2b_final_ready", 32'(pix_ready_o), 1);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
